trig_arbiter: RTL

TRIG_ARBITER -- requirements
Module: trig_arbiter

---
 rtl/trig_arbiter_if.sv | 39 +++
 rtl/trig_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/trig_arbiter_if.sv
// Request/response bundle shared by the trig_arbiter and its requesters and sine table.
// 'slave' is the arbiter side; 'master' is the requester/table side.
interface trig_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic        [NUM_REQ-1:0]   req_valid;
    logic        [NUM_REQ-1:0]   req_ready;
    logic        [9*NUM_REQ-1:0] req_angle;
    logic        [NUM_REQ-1:0]   req_cos;
    logic        [8:0]           lut_value;
    logic                        lut_valid;
    logic signed [31:0]          lut_amp;
    logic        [NUM_REQ-1:0]   resp_valid;
    logic signed [31:0]          resp_amp;

    modport slave (
        input  req_valid,
        input  req_angle,
        input  req_cos,
        input  lut_amp,
        output req_ready,
        output lut_value,
        output lut_valid,
        output resp_valid,
        output resp_amp
    );

    modport master (
        output req_valid,
        output req_angle,
        output req_cos,
        output lut_amp,
        input  req_ready,
        input  lut_value,
        input  lut_valid,
        input  resp_valid,
        input  resp_amp
    );
endinterface

// File: rtl/trig_arbiter.sv
// Round-robin arbiter sharing one half-wave sine table between NUM_REQ requesters.
// Angles are folded onto 0..179 degrees; the sign is restored when the table answers.
module trig_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int LUT_LATENCY = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    trig_arbiter_if.slave bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int STAGES = LUT_LATENCY + 1;
    localparam int DATA_W = 32;
    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

    // Returns {negate, index}: index in 0..179, negate when the angle lies in the lower half-wave.
    function automatic logic [9:0] reduce_angle(input logic [8:0] angle, input logic use_cos);
        logic [9:0] a;
        a = (angle >= 9'd360) ? {1'b0, angle - 9'd360} : {1'b0, angle};
        if (use_cos) begin
            a = a + 10'd90;
            if (a >= 10'd360) begin
                a = a - 10'd360;
            end
        end
        if (a >= 10'd180) begin
            return {1'b1, 9'(a - 10'd180)};
        end
        return {1'b0, a[8:0]};
    endfunction

    function automatic logic signed [DATA_W-1:0] apply_sign(
        input logic signed [DATA_W-1:0] amp,
        input logic                     neg
    );
        return neg ? -amp : amp;
    endfunction

    logic [ID_W-1:0]     r_last;
    logic [NUM_REQ-1:0]  w_ready;
    logic                w_gnt;
    logic [ID_W-1:0]     w_gnt_id;
    logic [ID_W:0]       w_sum;
    logic [ID_W-1:0]     w_cand;
    logic [8:0]          w_angle;
    logic                w_cos;
    logic [9:0]          w_red;

    // Stage p0: grant search starting one past the last winner, then angle folding.
    always_comb begin
        w_ready  = '0;
        w_gnt    = 1'b0;
        w_gnt_id = '0;
        w_sum    = '0;
        w_cand   = '0;
        w_angle  = '0;
        w_cos    = 1'b0;
        w_red    = '0;
        if (!rst_in) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_sum  = {1'b0, r_last} + (ID_W+1)'(k);
                w_cand = (w_sum >= NREQ) ? ID_W'(w_sum - NREQ) : ID_W'(w_sum);
                if (!w_gnt && bus.req_valid[w_cand]) begin
                    w_gnt    = 1'b1;
                    w_gnt_id = w_cand;
                end
            end
            if (w_gnt) begin
                w_ready[w_gnt_id] = 1'b1;
            end
        end
        w_angle = bus.req_angle[9*w_gnt_id +: 9];
        w_cos   = bus.req_cos[w_gnt_id];
        w_red   = reduce_angle(w_angle, w_cos);
    end

    assign bus.req_ready = w_ready;

    logic [8:0]          r_lut_value_p0;
    logic                r_vld_pl [STAGES];
    logic [ID_W-1:0]     r_id_pl  [STAGES];
    logic                r_neg_pl [STAGES];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_last         <= ID_W'(NUM_REQ-1);
            r_lut_value_p0 <= '0;
        end else if (w_gnt) begin
            r_last         <= w_gnt_id;
            r_lut_value_p0 <= w_red[8:0];
        end
    end

    // Stage p1..pL: tag pipeline kept in step with the table's answer.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < STAGES; s++) begin
                r_vld_pl[s] <= 1'b0;
            end
        end else begin
            r_vld_pl[0] <= w_gnt;
            for (int s = 1; s < STAGES; s++) begin
                r_vld_pl[s] <= r_vld_pl[s-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        r_id_pl[0]  <= w_gnt_id;
        r_neg_pl[0] <= w_red[9];
        for (int s = 1; s < STAGES; s++) begin
            r_id_pl[s]  <= r_id_pl[s-1];
            r_neg_pl[s] <= r_neg_pl[s-1];
        end
    end

    assign bus.lut_value = r_lut_value_p0;
    assign bus.lut_valid = r_vld_pl[0];

    logic [NUM_REQ-1:0]        r_resp_vld;
    logic signed [DATA_W-1:0]  r_resp_amp;

    // Result stage: sign restore and one-cycle strobe to the owner.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_resp_vld <= '0;
            r_resp_amp <= '0;
        end else begin
            r_resp_vld <= '0;
            if (r_vld_pl[STAGES-1]) begin
                r_resp_vld[r_id_pl[STAGES-1]] <= 1'b1;
                r_resp_amp <= apply_sign(bus.lut_amp, r_neg_pl[STAGES-1]);
            end
        end
    end

    assign bus.resp_valid = r_resp_vld;
    assign bus.resp_amp   = r_resp_amp;

endmodule
